// File: rtl/simplespislave_pkg.sv
// Shared constants for the SPI target: status bit positions, write-1-to-clear bits, default idle byte.
package simplespislave_pkg;

  localparam int unsigned ST_RX_NE  = 0;
  localparam int unsigned ST_RX_FULL = 1;
  localparam int unsigned ST_TX_FULL = 2;
  localparam int unsigned ST_SEL    = 3;
  localparam int unsigned ST_OVR    = 4;
  localparam int unsigned ST_UDR    = 5;

  localparam int unsigned W1C_OVR = 12;
  localparam int unsigned W1C_UDR = 13;

  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/simplespislave_fifo.sv
// Show-ahead synchronous FIFO; pointers carry a wrap bit so full/empty need no counter.
module simplespislave_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/simplespislave.sv
// SPI mode-0 target with RX FIFO and single TX holding register, oversampled on clk.
// Optional registered interrupt output enabled by defining SIMPLESPISLAVE_IRQ_EN.
module simplespislave
  import simplespislave_pkg::*;
#(
  parameter int unsigned RX_DEPTH    = 4,
  parameter logic [7:0]  IDLE_BYTE   = DEFAULT_IDLE_BYTE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe,
  input  logic        reg_tx_we,
  input  logic        reg_rx_re,
  input  logic        reg_ctrl_we,
  input  logic [31:0] reg_di,
  output logic [31:0] reg_do,
  output logic        irq
);

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, csn_sync_q;
  logic                   sck_prev_q, csn_prev_q;
  logic                   sck_s, mosi_s, csn_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  logic       selected_q, selected_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_full_q, tx_full_d;
  logic       ovr_q, ovr_d, udr_q, udr_d;
  logic       push, reload, udr_set;
  logic       fifo_full, fifo_empty;
  logic [7:0] rx_head, status;
  logic       unused_di;

  // cs_n chain resets low so a controller still holding cs_n low after reset produces no select edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '0;
      sck_prev_q  <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
      sck_prev_q  <= sck_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~csn_s & csn_prev_q;
  assign cs_rise  = csn_s & ~csn_prev_q;

  always_comb begin
    selected_d = selected_q;
    bitcnt_d   = bitcnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    hold_d     = hold_q;
    tx_full_d  = tx_full_q;
    ovr_d      = ovr_q;
    udr_d      = udr_q;
    push       = 1'b0;
    reload     = 1'b0;
    udr_set    = 1'b0;

    if (cs_fall) begin
      selected_d = 1'b1;
      bitcnt_d   = 3'd0;
      reload     = 1'b1;
    end else if (cs_rise) begin
      selected_d = 1'b0;
      bitcnt_d   = 3'd0;
    end else if (selected_q) begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_s};
        bitcnt_d   = bitcnt_q + 3'd1;
        push       = (bitcnt_q == 3'd7);
      end else if (sck_fall) begin
        if (bitcnt_q == 3'd0) reload = 1'b1;
        else                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end

    if (reload) begin
      if (tx_full_q) begin
        tx_shift_d = hold_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
        udr_set    = 1'b1;
      end
    end
    // A CPU write in the reload cycle refills the holding register after the old value was taken.
    if (reg_tx_we) begin
      hold_d    = reg_di[7:0];
      tx_full_d = 1'b1;
    end

    if (reg_ctrl_we && reg_di[W1C_OVR]) ovr_d = 1'b0;
    if (reg_ctrl_we && reg_di[W1C_UDR]) udr_d = 1'b0;
    if (push && fifo_full && !reg_rx_re) ovr_d = 1'b1;
    if (udr_set) udr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selected_q <= 1'b0;
      bitcnt_q   <= 3'd0;
      tx_shift_q <= 8'hFF;
      tx_full_q  <= 1'b0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
    end else begin
      selected_q <= selected_d;
      bitcnt_q   <= bitcnt_d;
      tx_shift_q <= tx_shift_d;
      tx_full_q  <= tx_full_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    hold_q     <= hold_d;
  end

  simplespislave_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (reg_rx_re),
    .data_i  ({rx_shift_q[6:0], mosi_s}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (rx_head)
  );

  always_comb begin
    status             = '0;
    status[ST_RX_NE]   = ~fifo_empty;
    status[ST_RX_FULL] = fifo_full;
    status[ST_TX_FULL] = tx_full_q;
    status[ST_SEL]     = selected_q;
    status[ST_OVR]     = ovr_q;
    status[ST_UDR]     = udr_q;
  end

  assign reg_do    = {16'b0, status, rx_head};
  assign miso      = tx_shift_q[7];
  assign miso_oe   = selected_q;
  assign unused_di = ^{reg_di[31:14], reg_di[11:8]};

`ifdef SIMPLESPISLAVE_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= status[ST_RX_NE] | ovr_q | udr_q;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
